// File: rtl/adc_frame_capture.sv
// rtl/adc_frame_capture.sv - serial ADC frame deserialiser with channel tagging and FWFT output FIFO
// Captures DATA_W-bit MSB-first frames during read_sig windows and queues {word, channel} for a consumer.
module adc_frame_capture #(
  parameter  int DATA_W     = 16,
  parameter  int NUM_CH     = 8,
  parameter  int FIFO_DEPTH = 4,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              f_data_clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              read_sig,
  input  logic              adc_dout,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              scan_done,
  output logic              overflow,
  output logic              short_frame,
  input  logic              clr_flags
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BC_W  = $clog2(DATA_W + 1);
  localparam int ENT_W = DATA_W + CH_W;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [DATA_W-1:0]       shift_q, shift_d;
  logic [BC_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic [CH_W-1:0]         ch_cnt_q, ch_cnt_d;
  logic                    rs_q, rs_d;
  logic                    arm_q, arm_d;
  logic [ENT_W-1:0]        mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    scan_q, scan_d;
  logic                    ovf_q, ovf_d;
  logic                    short_q, short_d;

  logic                    rise;
  logic                    push_req;
  logic                    short_evt;
  logic                    ovf_evt;
  logic                    pop;
  logic                    full;
  logic                    accept;
  logic [DATA_W-1:0]       word;

  // arm_q blocks a window that was already open when reset released from counting as a rising edge
  assign rise = read_sig & ~rs_q & arm_q;
  assign word = {shift_q[DATA_W-2:0], adc_dout};

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    ch_cnt_d  = ch_cnt_q;
    push_req  = 1'b0;
    short_evt = 1'b0;
    rs_d      = read_sig;
    arm_d     = arm_q | ~read_sig;
    if (!enable) begin
      state_d   = IDLE;
      shift_d   = '0;
      bit_cnt_d = '0;
      ch_cnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            shift_d   = {{(DATA_W-1){1'b0}}, adc_dout};
            bit_cnt_d = BC_W'(1);
            state_d   = SHIFT;
          end
        end
        SHIFT: begin
          if (!read_sig) begin
            short_evt = 1'b1;
            shift_d   = '0;
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            shift_d = word;
            if (bit_cnt_q == BC_W'(DATA_W - 1)) begin
              push_req  = 1'b1;
              bit_cnt_d = '0;
              state_d   = HOLD;
              ch_cnt_d  = (ch_cnt_q == CH_W'(NUM_CH - 1)) ? '0 : ch_cnt_q + CH_W'(1);
            end else begin
              bit_cnt_d = bit_cnt_q + BC_W'(1);
            end
          end
        end
        HOLD: begin
          if (!read_sig) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop     = (count_q != '0) & out_ready;
  assign accept  = push_req & (~full | pop);
  assign ovf_evt = push_req & full & ~pop;

  always_comb begin
    mem_d = mem_q;
    if (accept) mem_d[wr_ptr_q] = {word, ch_cnt_q};
    wr_ptr_d = wr_ptr_q + PTR_W'(accept);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    scan_d  = accept & (ch_cnt_q == CH_W'(NUM_CH - 1));
    ovf_d   = (ovf_q & ~clr_flags) | ovf_evt;
    short_d = (short_q & ~clr_flags) | short_evt;
  end

  always_ff @(posedge f_data_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      ch_cnt_q  <= '0;
      rs_q      <= 1'b0;
      arm_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      scan_q    <= 1'b0;
      ovf_q     <= 1'b0;
      short_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      ch_cnt_q  <= ch_cnt_d;
      rs_q      <= rs_d;
      arm_q     <= arm_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      scan_q    <= scan_d;
      ovf_q     <= ovf_d;
      short_q   <= short_d;
    end
  end

  assign out_data    = mem_q[rd_ptr_q][ENT_W-1:CH_W];
  assign out_ch      = mem_q[rd_ptr_q][CH_W-1:0];
  assign out_valid   = (count_q != '0);
  assign scan_done   = scan_q;
  assign overflow    = ovf_q;
  assign short_frame = short_q;

endmodule
